// File: rtl/pc_sequencer.sv
// Registered program counter for the fetch stage.
// Selects the next PC among sequential, conditional/unconditional branch,
// call (BL, with return-address push) and return (RET, with RAS pop).
// The PC and stack only move when fetch accepts the current address (Advance).
module pc_sequencer #(
    parameter int                  PC_WIDTH     = 64,
    parameter logic [PC_WIDTH-1:0] RESET_VECTOR = '0,
    parameter int                  INSTR_BYTES  = 4,
    parameter int                  IMM_SHIFT    = 0,
    parameter int                  RAS_DEPTH    = 4
) (
    input  logic                         CLK,
    input  logic                         Reset,
    input  logic                         Advance,
    input  logic [PC_WIDTH-1:0]          SignExtImm,
    input  logic                         Branch,
    input  logic                         BranchNZ,
    input  logic                         ALUZero,
    input  logic                         Uncondbranch,
    input  logic                         Call,
    input  logic                         Ret,
    input  logic [PC_WIDTH-1:0]          RegTarget,
    output logic [PC_WIDTH-1:0]          CurrentPC,
    output logic [PC_WIDTH-1:0]          NextPC,
    output logic [$clog2(RAS_DEPTH):0]   RasCount,
    output logic                         RasOverflow,
    output logic                         RasUnderflow
);

    localparam int PTR_W = $clog2(RAS_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [PC_WIDTH-1:0] rasMem [RAS_DEPTH];
    logic [PTR_W-1:0]    rasPtr;     // next free slot; top of stack is rasPtr-1
    logic [PTR_W-1:0]    topIdx;
    logic [PC_WIDTH-1:0] seqPC;
    logic [PC_WIDTH-1:0] tgtPC;
    logic                takeBranch;
    logic                rasEmpty;
    logic                rasFull;
    logic                pushEn;

    assign seqPC      = CurrentPC + PC_WIDTH'(INSTR_BYTES);
    assign tgtPC      = CurrentPC + (SignExtImm << IMM_SHIFT);
    assign takeBranch = Branch & (ALUZero ^ BranchNZ);
    assign topIdx     = rasPtr - PTR_W'(1);
    assign rasEmpty   = (RasCount == '0);
    assign rasFull    = (RasCount == CNT_W'(RAS_DEPTH));
    // Ret outranks Call, so a simultaneous Call+Ret never pushes.
    assign pushEn     = Advance & ~Reset & Call & ~Ret;

    // Next-PC selection in priority order: return, call/jump, taken branch, sequential.
    always_comb begin
        NextPC = seqPC;
        if (Ret) begin
            NextPC = rasEmpty ? RegTarget : rasMem[topIdx];
        end else if (Call || Uncondbranch) begin
            NextPC = tgtPC;
        end else if (takeBranch) begin
            NextPC = tgtPC;
        end
    end

    // Return-address storage; contents need no reset because RasCount gates every read.
    always_ff @(posedge CLK) begin
        if (pushEn) begin
            rasMem[rasPtr] <= seqPC;
        end
    end

    // PC, stack pointer/count and sticky error flags.
    always_ff @(posedge CLK) begin
        if (Reset) begin
            CurrentPC    <= RESET_VECTOR;
            rasPtr       <= '0;
            RasCount     <= '0;
            RasOverflow  <= 1'b0;
            RasUnderflow <= 1'b0;
        end else if (Advance) begin
            CurrentPC <= NextPC;
            if (Ret) begin
                if (rasEmpty) begin
                    RasUnderflow <= 1'b1;
                end else begin
                    rasPtr   <= rasPtr - PTR_W'(1);
                    RasCount <= RasCount - CNT_W'(1);
                end
            end else if (Call) begin
                // A full stack keeps the newest entries: the write lands on the oldest slot.
                rasPtr <= rasPtr + PTR_W'(1);
                if (rasFull) begin
                    RasOverflow <= 1'b1;
                end else begin
                    RasCount <= RasCount + CNT_W'(1);
                end
            end
        end
    end

endmodule
